// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL wrapper side and the reset sequencer.
// The slave modport is the sequencer's view; master is the driving environment.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       btn_n;
    logic       sys_resetn;
    logic [1:0] state;
    logic [7:0] relock_count;

    modport master (
        output pll_lock,
        output btn_n,
        input  sys_resetn,
        input  state,
        input  relock_count
    );

    modport slave (
        input  pll_lock,
        input  btn_n,
        output sys_resetn,
        output state,
        output relock_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Generates a clean registered system reset from PLL lock and a bouncing reset button:
// waits for stable lock, stretches reset, and re-enters reset on lock loss or a press.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int DEBOUNCE_CYCLES    = 4096
) (
    input logic                  clk,
    input logic                  resetn,
    pll_reset_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STABILIZE = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q,    lock_s_d;
    logic             btn_meta_q,  btn_meta_d;
    logic             btn_s_q,     btn_s_d;
    logic [DEB_W-1:0] deb_cnt_q,   deb_cnt_d;
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sys_resetn_q, sys_resetn_d;
    logic [7:0]       relock_q,    relock_d;
    logic             press;

    // Press is a level: it stays asserted for as long as the synced button stays low.
    assign press = !btn_s_q && (deb_cnt_q == DEB_LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        lock_meta_d  = bus.pll_lock;
        lock_s_d     = lock_meta_q;
        btn_meta_d   = bus.btn_n;
        btn_s_d      = btn_meta_q;
        deb_cnt_d    = deb_cnt_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        sys_resetn_d = sys_resetn_q;
        relock_d     = relock_q;

        if (btn_s_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_LAST) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end

        case (state_q)
            S_WAIT_LOCK: begin
                sys_resetn_d = 1'b0;
                if (lock_s_q) begin
                    state_d = S_STABILIZE;
                    cnt_d   = '0;
                end
            end
            S_STABILIZE: begin
                sys_resetn_d = 1'b0;
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                sys_resetn_d = 1'b0;
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (press) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Release reset on the same edge that enters RUN.
                    state_d      = S_RUN;
                    cnt_d        = '0;
                    sys_resetn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                sys_resetn_d = 1'b1;
                if (!lock_s_q) begin
                    state_d      = S_WAIT_LOCK;
                    cnt_d        = '0;
                    sys_resetn_d = 1'b0;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end else if (press) begin
                    state_d      = S_HOLD;
                    cnt_d        = '0;
                    sys_resetn_d = 1'b0;
                end
            end
        endcase
    end

    // Button synchroniser resets to 1 so a released button is the power-up view.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            btn_meta_q   <= 1'b1;
            btn_s_q      <= 1'b1;
            deb_cnt_q    <= '0;
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= '0;
            sys_resetn_q <= 1'b0;
            relock_q     <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            btn_meta_q   <= btn_meta_d;
            btn_s_q      <= btn_s_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_resetn_q <= sys_resetn_d;
            relock_q     <= relock_d;
        end
    end

    assign bus.sys_resetn   = sys_resetn_q;
    assign bus.state        = state_q;
    assign bus.relock_count = relock_q;

endmodule
